and3: RTL and testbench
=======================

# and3

Registered, handshaked 3-input bitwise logic gate serving both the AND3 and OR3 roles, selected by parameter. It sits in the gate-level datapath library and feeds downstream consumers through a one-entry valid/ready output stage. The OR3 function is the same block built with `MODE = 1`; there is no separate RTL.

## Interface
- `WIDTH`, default 1: bit width of each input lane and of `o`.
- `MODE`, default 0: gate function; 0 = AND (`o = i1 & i2 & i3`), 1 = OR (`o = i1 | i2 | i3`). Any other value is an elaboration error.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `i1`/`i2`/`i3` carry an operand triple.
- `in_ready` output 1: block accepts the triple this cycle.
- `i1` input WIDTH: operand 1, bit 0 of the test vector convention.
- `i2` input WIDTH: operand 2.
- `i3` input WIDTH: operand 3.
- `out_valid` output 1: `o` holds a result.
- `out_ready` input 1: consumer takes `o` this cycle.
- `o` output WIDTH: registered gate result.
- `all_ones_cnt` output CNT_W: present only with `AND3_STATS_EN`.
- `xfer_cnt` output CNT_W: present only with `AND3_STATS_EN`.

## Operation
- The result is a bitwise function per lane. Lane k of `o` depends only on lane k of `i1`, `i2` and `i3`.
- `in_ready = !out_valid || out_ready`. This is combinational and has no dependence on `in_valid`.
- Accept occurs when `in_valid && in_ready`. On the next edge, `o` is loaded with the gate function of the inputs and `out_valid` is set to 1.
- Drain occurs when `out_valid && out_ready` without an accept in the same cycle. On the next edge, `out_valid` goes to 0 and `o` holds its last value.
- Drain and accept in the same cycle: `o` is reloaded and `out_valid` stays 1. There is no bubble.
- While `out_valid && !out_ready`, `o` and `out_valid` stay stable. Input lanes are don't-care.
- When `in_valid` is 0, the input lanes are don't-care, including X.

## Timing
- Latency is 1 cycle from accept to `out_valid`.
- Throughput is 1 triple per cycle when `out_ready` is held high.
- Reset values: `o = 0`, `out_valid = 0`, both counters 0. `in_ready` is 1 during and immediately after reset.
- Reset mid-operation discards any pending result. Reset has priority over accept and drain in the same cycle.
- There are no combinational paths from `i1`/`i2`/`i3` to `o`. The only combinational path to an output is `out_ready` to `in_ready`.

## Configuration
- `AND3_STATS_EN` defined: adds two saturating counters, updated on the edge after the event.
  - `xfer_cnt` increments on every output drain (`out_valid && out_ready`).
  - `all_ones_cnt` increments on every drain where `o` is all-ones.
  - Both counters saturate at `2**CNT_W-1` and clear on `rst`.
- `AND3_STATS_EN` not defined: the counter logic and both ports are absent. Handshake and datapath behaviour are identical in both builds.

## Structure
- Shared package `and3_pkg` contains:
  - `gate_mode_e` enum: `GATE_AND = 0`, `GATE_OR = 1`.
  - Default `CNT_W` constant.
  - Saturating-increment function.
- One sub-module, `gate3_core`: purely combinational, parameterized by `WIDTH` and `MODE`, computes the bitwise function.
- The top level holds the output register, the handshake and the optional counters.

## Test plan
- `MODE = 0`, `WIDTH = 1`, `out_ready = 1`, sweep `{i3,i2,i1}` from 3'b000 to 3'b111, one per cycle: `o` is 1 only for 3'b111, one cycle after each accept.
- `MODE = 1`, same sweep: `o` is 0 only for 3'b000, and 1 for the other seven.
- `WIDTH = 4`, `MODE = 0`, `i1 = 4'b1111`, `i2 = 4'b1010`, `i3 = 4'b0110`: `o = 4'b0010`. With `MODE = 1`: `o = 4'b1111`.
- Accept a triple, then hold `out_ready = 0` for 3 cycles while inputs change:
  - `in_ready` is 0.
  - `o` and `out_valid` stay stable.
  - Raising `out_ready` with `in_valid` high gives a back-to-back reload with `out_valid` staying 1.
- Assert `rst` one cycle after an accept: next cycle `out_valid = 0`, `o = 0`, and the result never appears.
- With `AND3_STATS_EN`, `CNT_W = 2`, `MODE = 1`, drain 5 results all equal to 1:
  - `xfer_cnt` and `all_ones_cnt` saturate at 3.
  - `rst` returns both to 0.

Source files
------------

// File: rtl/and3_pkg.sv
// and3_pkg: shared gate-mode enum, default counter width and saturating increment.
package and3_pkg;

  typedef enum logic {
    GATE_AND = 1'b0,
    GATE_OR  = 1'b1
  } gate_mode_e;

  localparam int CNT_W_DEFAULT = 16;

  // Counter value lives in the low w bits; it sticks once it reaches all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    return (v == (32'hFFFF_FFFF >> (32 - w))) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/gate3_core.sv
// gate3_core: combinational 3-input bitwise AND (MODE 0) or OR (MODE 1).
module gate3_core
  import and3_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int MODE  = 0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] y_o
);

  if (MODE != int'(GATE_AND) && MODE != int'(GATE_OR)) begin : g_bad_mode
    $error("gate3_core: MODE must be 0 (AND) or 1 (OR)");
  end

  assign y_o = (MODE == int'(GATE_OR)) ? (a_i | b_i | c_i) : (a_i & b_i & c_i);

endmodule

// File: rtl/and3.sv
// and3: registered, valid/ready handshaked 3-input AND/OR gate.
// Define AND3_STATS_EN to add saturating drain / all-ones-drain counters.
module and3
  import and3_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int MODE  = 0,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o
`ifdef AND3_STATS_EN
  ,
  output logic [CNT_W-1:0] all_ones_cnt,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);

  logic [WIDTH-1:0] g, o_q, o_d;
  logic             valid_q, valid_d, accept;

  gate3_core #(.WIDTH(WIDTH), .MODE(MODE)) u_core (
    .a_i(i1),
    .b_i(i2),
    .c_i(i3),
    .y_o(g)
  );

  always_comb begin
    in_ready = !valid_q || out_ready;
    accept   = in_valid && in_ready;
    o_d      = accept ? g : o_q;
    valid_d  = accept || (valid_q && !out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      o_q     <= o_d;
      valid_q <= valid_d;
    end
  end

  assign o         = o_q;
  assign out_valid = valid_q;

`ifdef AND3_STATS_EN
  logic [CNT_W-1:0] xfer_q, ones_q;
  logic             drain;

  assign drain = valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_q <= '0;
      ones_q <= '0;
    end else if (drain) begin
      xfer_q <= CNT_W'(sat_inc(32'(xfer_q), CNT_W));
      if (&o_q) ones_q <= CNT_W'(sat_inc(32'(ones_q), CNT_W));
    end
  end

  assign xfer_cnt     = xfer_q;
  assign all_ones_cnt = ones_q;
`endif

endmodule

// File: tb/tb_and3.sv
// tb_and3: randomized and directed checks of and3 against a lane-counting reference model.
module tb_and3;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic [3:0] i1, i2, i3;
  logic       rdy_a, rdy_o, rdy_1, v_a, v_o, v_1;
  logic [3:0] o_a, o_o;
  logic       o_1;
`ifdef AND3_STATS_EN
  logic [1:0] xa, aa, xo, ao, x1, a1;
`endif

  int n_chk = 0, n_fail = 0;
  bit m_v = 1'b0;
  logic [3:0] m_a = '0, m_o = '0;
  int m_x = 0, m_oa = 0, m_oo = 0, m_o1 = 0;

  always #5 clk = ~clk;

  and3 #(.WIDTH(4), .MODE(0), .CNT_W(2)) u_and (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
    .i1(i1), .i2(i2), .i3(i3), .out_valid(v_a), .out_ready(out_ready), .o(o_a)
`ifdef AND3_STATS_EN
    , .all_ones_cnt(aa), .xfer_cnt(xa)
`endif
  );

  and3 #(.WIDTH(4), .MODE(1), .CNT_W(2)) u_or (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_o),
    .i1(i1), .i2(i2), .i3(i3), .out_valid(v_o), .out_ready(out_ready), .o(o_o)
`ifdef AND3_STATS_EN
    , .all_ones_cnt(ao), .xfer_cnt(xo)
`endif
  );

  and3 #(.WIDTH(1), .MODE(0), .CNT_W(2)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_1),
    .i1(i1[0]), .i2(i2[0]), .i3(i3[0]), .out_valid(v_1), .out_ready(out_ready), .o(o_1)
`ifdef AND3_STATS_EN
    , .all_ones_cnt(a1), .xfer_cnt(x1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each lane: AND means all three bits set, OR means at least one set.
  function automatic logic [3:0] ref_gate(input logic [3:0] a, b, c, input bit is_or);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) begin
      int s;
      s = int'(a[k]) + int'(b[k]) + int'(c[k]);
      r[k] = is_or ? (s > 0) : (s == 3);
    end
    return r;
  endfunction

  function automatic int sat2(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic step(input bit r_st, input bit v, input bit rdy, input logic [3:0] a, b, c);
    rst = r_st; in_valid = v; out_ready = rdy; i1 = a; i2 = b; i3 = c;
    #1;
    chk("in_ready", {rdy_a, rdy_o, rdy_1}, {3{!m_v || rdy}});
    if (r_st) begin
      m_v = 0; m_a = '0; m_o = '0; m_x = 0; m_oa = 0; m_oo = 0; m_o1 = 0;
    end else begin
      bit acc, drn;
      acc = v && (!m_v || rdy);
      drn = m_v && rdy;
      if (drn) begin
        m_x++;
        if (m_a == 4'hF) m_oa++;
        if (m_o == 4'hF) m_oo++;
        if (m_a[0]) m_o1++;
      end
      if (acc) begin
        m_v = 1; m_a = ref_gate(a, b, c, 0); m_o = ref_gate(a, b, c, 1);
      end else if (drn) m_v = 0;
    end
    @(negedge clk);
    chk("out_valid", {v_a, v_o, v_1}, {3{m_v}});
    chk("o_and4", o_a, m_a);
    chk("o_or4", o_o, m_o);
    chk("o_and1", o_1, m_a[0]);
`ifdef AND3_STATS_EN
    chk("xfer_cnt", {xa, xo, x1}, {3{2'(sat2(m_x))}});
    chk("ones_and4", aa, sat2(m_oa));
    chk("ones_or4", ao, sat2(m_oo));
    chk("ones_and1", a1, sat2(m_o1));
`endif
  endtask

  function automatic logic [3:0] rnd();
    return 4'($urandom);
  endfunction

  initial begin
    rst = 1; in_valid = 0; out_ready = 1; i1 = 0; i2 = 0; i3 = 0;
    @(negedge clk);
    step(1, 1, 0, rnd(), rnd(), rnd());
    step(1, 0, 1, rnd(), rnd(), rnd());
    step(0, 0, 1, rnd(), rnd(), rnd());
    // Truth-table sweep on lane 0, random upper lanes.
    for (int s = 0; s < 8; s++)
      step(0, 1, 1, {rnd()[3:1], s[0]}, {rnd()[3:1], s[1]}, {rnd()[3:1], s[2]});
    step(0, 0, 1, rnd(), rnd(), rnd());
    step(0, 1, 1, 4'b1111, 4'b1010, 4'b0110);
    chk("vec_and", o_a, 4'b0010);
    chk("vec_or", o_o, 4'b1111);
    // Backpressure: held result, then back-to-back reload.
    for (int k = 0; k < 3; k++) step(0, 1, 0, rnd(), rnd(), rnd());
    chk("bp_hold_and", o_a, 4'b0010);
    step(0, 1, 1, 4'b0101, 4'b0111, 4'b1101);
    chk("reload_valid", v_a, 1'b1);
    chk("reload_and", o_a, 4'b0101);
    step(0, 0, 1, rnd(), rnd(), rnd());
    // Reset right after an accept discards the result.
    step(0, 1, 0, 4'hF, 4'hF, 4'hF);
    step(1, 1, 1, 4'hF, 4'hF, 4'hF);
    step(0, 0, 1, rnd(), rnd(), rnd());
    step(0, 0, 1, rnd(), rnd(), rnd());
    // Five all-ones drains saturate the 2-bit counters.
    for (int k = 0; k < 5; k++) step(0, 1, 1, 4'hF, 4'hF, 4'hF);
    step(0, 0, 1, rnd(), rnd(), rnd());
    step(1, 0, 1, rnd(), rnd(), rnd());
    step(0, 0, 1, rnd(), rnd(), rnd());
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 31) == 0, 1'($urandom), 1'($urandom), rnd(), rnd(), rnd());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
